// File: rtl/lsu_sequencer_if.sv
// ---------------------------------------------------------------------------
// lsu_sequencer_if
//   Parallel memory request/acknowledge bus between the load/store
//   sequencer (master) and the memory side (slave).
//
//   mem_req   master->slave  request, held until mem_ack
//   mem_we    master->slave  write enable, valid with mem_req
//   mem_wstrb master->slave  byte strobes, valid with mem_req (0000 on loads)
//   mem_ack   slave->master  completion; read data stays stable until the
//                            next request
// ---------------------------------------------------------------------------
interface lsu_sequencer_if;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_wstrb;
    logic       mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wstrb,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wstrb,
        output mem_ack
    );
endinterface

// File: rtl/lsu_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_sequencer
//   Bit-serial load/store control stage sitting directly upstream of the
//   data serialiser. Walks the serialiser through address capture, store
//   data shift-in, the parallel memory handshake and load data shift-out,
//   and aborts misaligned accesses before any memory request is made.
//
// Parameters
//   TIMEOUT_CYCLES  request cycles to wait for mem_ack before bus_err
//                   (0 = wait forever)
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 one-cycle access request, ignored while busy
//   is_store, func        access type and funct3, sampled with start
//   addr_bit, store_bit   serial address / rs2 bits, LSB first
//   ser_bit_pos           current bit position (the 5-bit counter)
//   ser_mode              1 while the serialiser captures the address
//   ser_func              latched funct3
//   ser_data_in_bit       serial bit steered into the serialiser
//   ser_data_out_bit      serial load bit from the serialiser
//   ser_misaligned        misalignment flag from the serialiser
//   mem                   memory request bus (master side)
//   load_bit, load_valid  serial load result to the core, LSB first
//   busy                  high whenever not idle
//   done                  one-cycle pulse on successful completion
//   misaligned_err        one-cycle pulse on misaligned abort
//   bus_err               one-cycle pulse on request timeout
// ---------------------------------------------------------------------------
module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      func,
    input  logic            addr_bit,
    input  logic            store_bit,

    output logic [4:0]      ser_bit_pos,
    output logic            ser_mode,
    output logic [2:0]      ser_func,
    output logic            ser_data_in_bit,
    input  logic            ser_data_out_bit,
    input  logic            ser_misaligned,

    lsu_sequencer_if.master mem,

    output logic            load_bit,
    output logic            load_valid,
    output logic            busy,
    output logic            done,
    output logic            misaligned_err,
    output logic            bus_err
);

    // Wide enough to count up to TIMEOUT_CYCLES-1; at least one bit so the
    // disabled-timeout build still elaborates.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_SDATA,
        S_SREQ,
        S_LREQ,
        S_LDATA,
        S_DONE,
        S_ERR,
        S_TERR
    } state_t;

    state_t          state;
    logic [4:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic [2:0]      func_q;
    logic            store_q;
    logic [1:0]      addr_lo;

    logic            last_bit;
    logic            timeout_hit;

    assign ser_bit_pos = cnt;
    assign ser_func    = func_q;
    assign last_bit    = (cnt == 5'd31);

    // tcnt counts waiting cycles already spent; the cycle in which it reads
    // TIMEOUT_CYCLES-1 is the last one allowed, so the timeout fires after
    // exactly TIMEOUT_CYCLES request cycles without an ack.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(tcnt) == TIMEOUT_CYCLES - 1);

    // Byte strobes from access size (func[1:0]) and the captured low address
    // bits. Anything wider than a half is treated as a full word.
    function automatic logic [3:0] strb_for(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] s;
        case (sz)
            2'b00:   s = 4'b0001 << lo;
            2'b01:   s = 4'b0011 << {lo[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Serial input steering: address bits while capturing, rs2 bits while
    // shifting store data, quiet otherwise.
    always_comb begin
        ser_data_in_bit = 1'b0;
        if (state == S_ADDR)
            ser_data_in_bit = addr_bit;
        else if (state == S_SDATA)
            ser_data_in_bit = store_bit;
    end

    // load_valid is registered and high only in LDATA, so it gates the
    // serialiser output directly.
    assign load_bit = load_valid & ser_data_out_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 5'd0;
            tcnt           <= '0;
            func_q         <= 3'b000;
            store_q        <= 1'b0;
            addr_lo        <= 2'b00;
            ser_mode       <= 1'b0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_wstrb  <= 4'b0000;
            load_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle.
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ADDR;
                        cnt      <= 5'd0;
                        store_q  <= is_store;
                        func_q   <= func;
                        ser_mode <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                S_ADDR: begin
                    cnt <= cnt + 5'd1;
                    // Only the two low address bits matter here (strobes);
                    // the full address lives in the serialiser.
                    if (cnt[4:1] == 4'd0)
                        addr_lo[cnt[0]] <= addr_bit;
                    if (last_bit) begin
                        cnt      <= 5'd0;
                        ser_mode <= 1'b0;
                        if (ser_misaligned) begin
                            state          <= S_ERR;
                            misaligned_err <= 1'b1;
                        end else if (store_q) begin
                            state <= S_SDATA;
                        end else begin
                            state         <= S_LREQ;
                            tcnt          <= '0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= 1'b0;
                            mem.mem_wstrb <= 4'b0000;
                        end
                    end
                end

                S_SDATA: begin
                    cnt <= cnt + 5'd1;
                    if (last_bit) begin
                        state         <= S_SREQ;
                        cnt           <= 5'd0;
                        tcnt          <= '0;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_wstrb <= strb_for(func_q[1:0], addr_lo);
                    end
                end

                S_SREQ, S_LREQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (mem.mem_ack) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_wstrb <= 4'b0000;
                        cnt           <= 5'd0;
                        if (state == S_SREQ) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_LDATA;
                            load_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state         <= S_TERR;
                        bus_err       <= 1'b1;
                        cnt           <= 5'd0;
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_wstrb <= 4'b0000;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                S_LDATA: begin
                    cnt <= cnt + 5'd1;
                    if (last_bit) begin
                        state      <= S_DONE;
                        cnt        <= 5'd0;
                        load_valid <= 1'b0;
                        done       <= 1'b1;
                    end
                end

                S_DONE, S_ERR, S_TERR: begin
                    state <= S_IDLE;
                    cnt   <= 5'd0;
                    busy  <= 1'b0;
                end

                default: begin
                    state         <= S_IDLE;
                    cnt           <= 5'd0;
                    ser_mode      <= 1'b0;
                    mem.mem_req   <= 1'b0;
                    mem.mem_we    <= 1'b0;
                    mem.mem_wstrb <= 4'b0000;
                    load_valid    <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
